// File: rtl/div_2nbit_restore_if.sv
// Handshake and operand/result bundle for the 2N-by-N restoring divider.
interface div_2nbit_restore_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      i_vld;
  logic                      o_rdy;
  logic                      i_sign;
  logic [2*DATA_WIDTH-1:0]   i_num_x;
  logic [DATA_WIDTH-1:0]     i_num_y;
  logic                      o_end;
  logic [DATA_WIDTH-1:0]     o_quo;
  logic [DATA_WIDTH-1:0]     o_rem;
  logic                      o_ovf;
  logic                      o_dbz;

  modport master (
    output i_vld, i_sign, i_num_x, i_num_y,
    input  o_rdy, o_end, o_quo, o_rem, o_ovf, o_dbz
  );

  modport slave (
    input  i_vld, i_sign, i_num_x, i_num_y,
    output o_rdy, o_end, o_quo, o_rem, o_ovf, o_dbz
  );
endinterface

// File: rtl/div_2nbit_restore.sv
// Iterative radix-2 restoring divider: 2N-bit dividend / N-bit divisor,
// signed or unsigned, N-bit quotient and remainder with overflow and
// divide-by-zero flags. One quotient bit per cycle.
module div_2nbit_restore #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  div_2nbit_restore_if.slave bus
);
  localparam int unsigned N  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, PRE, CALC, FIX} state_t;

  state_t        state, state_nx;
  logic [N:0]    p;        // partial remainder
  logic [N-1:0]  qsr;      // low dividend half shifts out MSB-first, quotient bits shift in
  logic [N:0]    y_mag;
  logic [N-1:0]  x_lo;     // raw dividend low half, returned as remainder on divide-by-zero
  logic          sgn, neg_q, neg_r;
  logic [CW-1:0] cnt;

  logic [2*N-1:0] x_abs;
  logic [N:0]     y_ext, y_abs;
  logic [N:0]     shifted;
  logic [N+1:0]   diff;
  logic           ge;
  logic           range_ovf;
  logic [N-1:0]   quo_fix, rem_fix;

  assign bus.o_rdy = (state == IDLE);

  // Operand magnitudes, trial subtraction and sign fix-up.
  always_comb begin
    x_abs     = (bus.i_sign && bus.i_num_x[2*N-1]) ? -bus.i_num_x : bus.i_num_x;
    y_ext     = {bus.i_sign & bus.i_num_y[N-1], bus.i_num_y};
    y_abs     = y_ext[N] ? -y_ext : y_ext;
    shifted   = {p[N-1:0], qsr[N-1]};
    diff      = {1'b0, shifted} - {1'b0, y_mag};
    ge        = ~diff[N+1];
    range_ovf = neg_q ? (qsr[N-1] && (|qsr[N-2:0])) : qsr[N-1];
    quo_fix   = neg_q ? -qsr : qsr;
    rem_fix   = neg_r ? -p[N-1:0] : p[N-1:0];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_vld) state_nx = PRE;
      PRE:     state_nx = ((y_mag == '0) || (p >= y_mag)) ? IDLE : CALC;
      CALC:    if (cnt == CW'(N-1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p         <= '0;
      qsr       <= '0;
      y_mag     <= '0;
      x_lo      <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      bus.o_end <= 1'b0;
      bus.o_quo <= '0;
      bus.o_rem <= '0;
      bus.o_ovf <= 1'b0;
      bus.o_dbz <= 1'b0;
    end else begin
      bus.o_end <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_vld) begin
            sgn   <= bus.i_sign;
            neg_q <= bus.i_sign & (bus.i_num_x[2*N-1] ^ bus.i_num_y[N-1]);
            neg_r <= bus.i_sign & bus.i_num_x[2*N-1];
            y_mag <= y_abs;
            // P is preloaded with |x| high half here so PRE can range-check it directly.
            p     <= {1'b0, x_abs[2*N-1:N]};
            qsr   <= x_abs[N-1:0];
            x_lo  <= bus.i_num_x[N-1:0];
            cnt   <= '0;
          end
        end
        PRE: begin
          if (y_mag == '0) begin
            bus.o_dbz <= 1'b1;
            bus.o_ovf <= 1'b1;
            bus.o_quo <= '1;
            bus.o_rem <= x_lo;
            bus.o_end <= 1'b1;
          end else if (p >= y_mag) begin
            bus.o_dbz <= 1'b0;
            bus.o_ovf <= 1'b1;
            bus.o_quo <= '0;
            bus.o_rem <= '0;
            bus.o_end <= 1'b1;
          end
        end
        CALC: begin
          p   <= ge ? diff[N:0] : shifted;
          qsr <= {qsr[N-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          bus.o_end <= 1'b1;
          bus.o_dbz <= 1'b0;
          if (sgn && range_ovf) begin
            bus.o_ovf <= 1'b1;
            bus.o_quo <= '0;
            bus.o_rem <= '0;
          end else begin
            bus.o_ovf <= 1'b0;
            bus.o_quo <= quo_fix;
            bus.o_rem <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
